// File: rtl/cgra0_out_stream_writer.sv
// -----------------------------------------------------------------------------
// cgra0_out_stream_writer
//
// Transmitting end of the per-thread ignore/quantity stream protocol. Result
// beats from the PE array arrive tagged with a thread index. For each thread
// the first ign_lim beats are discarded. Optionally at most qtd_lim beats are
// forwarded, and any further beats are dropped. Forwarded beats pass through a
// 2-entry skid buffer into the accelerator output FIFO.
//
// Optional feature macro: CGRA_OUT_QTD_EN
//   defined   : 64-bit per-thread quantity limits/counters gate forwarding.
//   undefined : every post-ignore beat is forwarded; cfg_qtd_* are ignored.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   en                  global enable; low freezes all but config writes
//   in_valid/thread/data  result beat from the PE array
//   cfg_thread_id       thread targeted by the config strobes
//   cfg_ignore_we/ignore  load ignore limit (clears ignore counter)
//   cfg_qtd_we_low/high, cfg_qtd_low/high  load quantity halves (clears count)
//   fifo_full           output FIFO cannot accept
//   fifo_we, fifo_data  registered output FIFO write
//   stall               skid buffer full
//   overflow            sticky: a beat was lost to a full buffer
//   done                per-thread limits reached
// -----------------------------------------------------------------------------
module cgra0_out_stream_writer #(
    parameter int NUM_THREADS  = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int IGNORE_WIDTH = 16,
    parameter int QTD_WIDTH    = 64,
    parameter int TID_WIDTH    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [TID_WIDTH-1:0]     in_thread,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [TID_WIDTH-1:0]     cfg_thread_id,
    input  logic                     cfg_ignore_we,
    input  logic [IGNORE_WIDTH-1:0]  cfg_ignore,
    input  logic                     cfg_qtd_we_low,
    input  logic                     cfg_qtd_we_high,
    input  logic [QTD_WIDTH/2-1:0]   cfg_qtd_low,
    input  logic [QTD_WIDTH/2-1:0]   cfg_qtd_high,
    input  logic                     fifo_full,
    output logic                     fifo_we,
    output logic [DATA_WIDTH-1:0]    fifo_data,
    output logic                     stall,
    output logic                     overflow,
    output logic [NUM_THREADS-1:0]   done
);

    localparam logic [TID_WIDTH-1:0] MAX_TID = TID_WIDTH'(NUM_THREADS - 1);

    logic [IGNORE_WIDTH-1:0] ign_lim [NUM_THREADS];
    logic [IGNORE_WIDTH-1:0] ign_cnt [NUM_THREADS];

    logic [NUM_THREADS-1:0] ign_cfg_hit;
    logic [NUM_THREADS-1:0] cfg_hit;      // any config strobe on this thread
    logic [NUM_THREADS-1:0] beat_sel;     // counted beat for this thread
    logic [NUM_THREADS-1:0] ign_open;     // still in ignore phase
    logic [NUM_THREADS-1:0] ign_done;
    logic [NUM_THREADS-1:0] qtd_open;     // quantity not yet reached
    logic                   beat_ok;
    logic                   push;

    // skid buffer
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  pop;
    logic                  accept;

    assign beat_ok = en & in_valid & (in_thread <= MAX_TID);

    always_comb begin
        ign_cfg_hit = '0;
        beat_sel    = '0;
        ign_open    = '0;
        ign_done    = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            ign_cfg_hit[t] = cfg_ignore_we & (cfg_thread_id == TID_WIDTH'(t));
            // A config write to the same thread wins; the beat is dropped.
            beat_sel[t]    = beat_ok & (in_thread == TID_WIDTH'(t)) & ~cfg_hit[t];
            ign_open[t]    = ign_cnt[t] < ign_lim[t];
            ign_done[t]    = ign_cnt[t] == ign_lim[t];
        end
    end

    assign push = |(beat_sel & ~ign_open & qtd_open);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                ign_lim[t] <= '0;
                ign_cnt[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (ign_cfg_hit[t]) begin
                    ign_lim[t] <= cfg_ignore;
                    ign_cnt[t] <= '0;
                end else if (beat_sel[t] && ign_open[t]) begin
                    ign_cnt[t] <= ign_cnt[t] + IGNORE_WIDTH'(1);
                end
            end
        end
    end

`ifdef CGRA_OUT_QTD_EN
    logic [QTD_WIDTH-1:0]   qtd_lim [NUM_THREADS];
    logic [QTD_WIDTH-1:0]   qtd_cnt [NUM_THREADS];
    logic [NUM_THREADS-1:0] qtd_cfg_hit;

    always_comb begin
        qtd_cfg_hit = '0;
        qtd_open    = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            qtd_cfg_hit[t] = (cfg_qtd_we_low | cfg_qtd_we_high)
                           & (cfg_thread_id == TID_WIDTH'(t));
            qtd_open[t]    = qtd_cnt[t] != qtd_lim[t];
        end
    end

    assign cfg_hit = ign_cfg_hit | qtd_cfg_hit;
    assign done    = ign_done & ~qtd_open;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                qtd_lim[t] <= '0;
                qtd_cnt[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (qtd_cfg_hit[t]) begin
                    if (cfg_qtd_we_low)
                        qtd_lim[t][QTD_WIDTH/2-1:0] <= cfg_qtd_low;
                    if (cfg_qtd_we_high)
                        qtd_lim[t][QTD_WIDTH-1:QTD_WIDTH/2] <= cfg_qtd_high;
                    qtd_cnt[t] <= '0;
                end else if (beat_sel[t] && !ign_open[t] && qtd_open[t]) begin
                    qtd_cnt[t] <= qtd_cnt[t] + QTD_WIDTH'(1);
                end
            end
        end
    end
`else
    logic unused_qtd_cfg;
    assign unused_qtd_cfg = ^{cfg_qtd_we_low, cfg_qtd_we_high, cfg_qtd_low, cfg_qtd_high};

    assign qtd_open = '1;
    assign cfg_hit  = ign_cfg_hit;
    assign done     = ign_done;
`endif

    assign stall  = (count == 2'd2);
    assign pop    = en & ~fifo_full & (count != 2'd0);
    // A full buffer still takes a beat if the head leaves in the same cycle.
    assign accept = push & ((count != 2'd2) | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            overflow   <= 1'b0;
            fifo_we    <= 1'b0;
            fifo_data  <= '0;
        end else begin
            if (accept) begin
                buf_mem[wr_ptr] <= in_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                fifo_data <= buf_mem[rd_ptr];
            end
            fifo_we <= pop;
            if (push && !accept)
                overflow <= 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra0_out_stream_writer.sv
module tb_cgra0_out_stream_writer;

`ifdef CGRA_OUT_QTD_EN
    localparam bit QTD = 1'b1;
`else
    localparam bit QTD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [2:0]  in_thread;
    logic [31:0] in_data;
    logic [2:0]  cfg_thread_id;
    logic        cfg_ignore_we;
    logic [15:0] cfg_ignore;
    logic        cfg_qtd_we_low;
    logic        cfg_qtd_we_high;
    logic [31:0] cfg_qtd_low;
    logic [31:0] cfg_qtd_high;
    logic        fifo_full;
    logic        fifo_we;
    logic [31:0] fifo_data;
    logic        stall;
    logic        overflow;
    logic [6:0]  done;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    cgra0_out_stream_writer dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .in_valid        (in_valid),
        .in_thread       (in_thread),
        .in_data         (in_data),
        .cfg_thread_id   (cfg_thread_id),
        .cfg_ignore_we   (cfg_ignore_we),
        .cfg_ignore      (cfg_ignore),
        .cfg_qtd_we_low  (cfg_qtd_we_low),
        .cfg_qtd_we_high (cfg_qtd_we_high),
        .cfg_qtd_low     (cfg_qtd_low),
        .cfg_qtd_high    (cfg_qtd_high),
        .fifo_full       (fifo_full),
        .fifo_we         (fifo_we),
        .fifo_data       (fifo_data),
        .stall           (stall),
        .overflow        (overflow),
        .done            (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected beat.
    initial begin
        logic [31:0] exp_d;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && fifo_we === 1'b1) begin
                if (sb.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL unexpected_write: actual=%0h required=no write", fifo_data);
                end else begin
                    exp_d = sb.pop_front();
                    check("fifo_data", 64'(fifo_data), 64'(exp_d));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end at a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input logic [2:0] t, input logic [31:0] d, input bit exp_w);
        in_valid  = 1'b1;
        in_thread = t;
        in_data   = d;
        if (exp_w) sb.push_back(d);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic cfg_ign(input logic [2:0] t, input logic [15:0] v);
        cfg_thread_id = t;
        cfg_ignore    = v;
        cfg_ignore_we = 1'b1;
        @(negedge clk);
        cfg_ignore_we = 1'b0;
    endtask

    task automatic cfg_qtd(input logic [2:0] t, input logic [63:0] v);
        cfg_thread_id   = t;
        cfg_qtd_low     = v[31:0];
        cfg_qtd_high    = v[63:32];
        cfg_qtd_we_low  = 1'b1;
        cfg_qtd_we_high = 1'b1;
        @(negedge clk);
        cfg_qtd_we_low  = 1'b0;
        cfg_qtd_we_high = 1'b0;
    endtask

    task automatic beat_cfg(input logic [2:0] bt, input logic [31:0] d, input bit exp_w,
                            input logic [2:0] ct, input logic [15:0] iv);
        in_valid      = 1'b1;
        in_thread     = bt;
        in_data       = d;
        cfg_thread_id = ct;
        cfg_ignore    = iv;
        cfg_ignore_we = 1'b1;
        if (exp_w) sb.push_back(d);
        @(negedge clk);
        in_valid      = 1'b0;
        cfg_ignore_we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_thread = '0; in_data = '0;
        cfg_thread_id = '0; cfg_ignore_we = 1'b0; cfg_ignore = '0;
        cfg_qtd_we_low = 1'b0; cfg_qtd_we_high = 1'b0; cfg_qtd_low = '0; cfg_qtd_high = '0;
        fifo_full = 1'b0;

        idle(3);
        check("rst_fifo_we",   64'(fifo_we),   64'd0);
        check("rst_fifo_data", 64'(fifo_data), 64'd0);
        check("rst_stall",     64'(stall),     64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_done",      64'(done),      64'h7F);
        rst = 1'b1;
        idle(1);

        // Thread 0: ignore 2, quantity 3, beats 0xA..0xF.
        cfg_ign(3'd0, 16'd2);
        cfg_qtd(3'd0, 64'd3);
        check("t0_done_cfg", 64'(done[0]), 64'd0);
        beat(3'd0, 32'hA, 1'b0);
        beat(3'd0, 32'hB, 1'b0);
        beat(3'd0, 32'hC, 1'b1);
        beat(3'd0, 32'hD, 1'b1);
        check("t0_done_4", 64'(done[0]), QTD ? 64'd0 : 64'd1);
        beat(3'd0, 32'hE, 1'b1);
        check("t0_done_5", 64'(done[0]), 64'd1);
        beat(3'd0, 32'hF, !QTD);
        idle(5);

        // Thread 3: single beat latency.
        cfg_ign(3'd3, 16'd0);
        cfg_qtd(3'd3, 64'd5);
        beat(3'd3, 32'h55, 1'b1);
        check("lat_k1_we",  64'(fifo_we),   64'd0);
        check("t3_done",    64'(done[3]),   QTD ? 64'd0 : 64'd1);
        idle(1);
        check("lat_k2_we",  64'(fifo_we),   64'd1);
        check("lat_k2_data",64'(fifo_data), 64'h55);
        idle(1);
        check("lat_k3_we",  64'(fifo_we),   64'd0);

        // Beat on thread 3 while config writes thread 4: both proceed.
        beat_cfg(3'd3, 32'h66, 1'b1, 3'd4, 16'd3);
        check("t4_done_cfg", 64'(done[4]), 64'd0);
        idle(4);

        // Thread 1: fifo_full held, three beats, overflow.
        cfg_ign(3'd1, 16'd0);
        cfg_qtd(3'd1, 64'd10);
        fifo_full = 1'b1;
        beat(3'd1, 32'h11, 1'b1);
        check("ovf_stall_1", 64'(stall), 64'd0);
        beat(3'd1, 32'h22, 1'b1);
        check("ovf_stall_2", 64'(stall), 64'd1);
        check("ovf_flag_2",  64'(overflow), 64'd0);
        beat(3'd1, 32'h33, 1'b0);
        check("ovf_flag_3",  64'(overflow), 64'd1);
        idle(2);
        check("ovf_no_we",   64'(fifo_we), 64'd0);
        fifo_full = 1'b0;
        idle(4);
        check("ovf_stall_drained", 64'(stall), 64'd0);
        check("ovf_sticky",  64'(overflow), 64'd1);

        // Thread 2: config and beat on same thread, same cycle.
        cfg_ign(3'd2, 16'd0);
        cfg_qtd(3'd2, 64'd10);
        beat_cfg(3'd2, 32'h77, 1'b0, 3'd2, 16'd1);
        check("t2_done_cfg", 64'(done[2]), 64'd0);
        beat(3'd2, 32'h88, 1'b0);
        check("t2_done_ign", 64'(done[2]), QTD ? 64'd0 : 64'd1);
        beat(3'd2, 32'h99, 1'b1);
        idle(4);

        // Thread 5: dropped beats leave counters alone.
        cfg_ign(3'd5, 16'd1);
        cfg_qtd(3'd5, 64'd10);
        en = 1'b0;
        beat(3'd5, 32'h5A, 1'b0);
        en = 1'b1;
        beat(3'd7, 32'h7E, 1'b0);
        check("t5_done_frozen", 64'(done[5]), 64'd0);
        beat(3'd5, 32'h5B, 1'b0);
        check("t5_done_ign", 64'(done[5]), QTD ? 64'd0 : 64'd1);

        // en low freezes a full buffer.
        fifo_full = 1'b1;
        beat(3'd5, 32'h5C, 1'b1);
        beat(3'd5, 32'h5D, 1'b1);
        en = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("en_low_we",    64'(fifo_we), 64'd0);
            check("en_low_stall", 64'(stall),   64'd1);
        end
        en = 1'b1;
        idle(4);

        // Reset mid-burst.
        fifo_full = 1'b1;
        beat(3'd5, 32'h61, 1'b0);
        beat(3'd5, 32'h62, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_we",       64'(fifo_we),  64'd0);
        check("mid_rst_stall",    64'(stall),    64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_done",     64'(done),     64'h7F);
        idle(1);
        rst = 1'b1;
        fifo_full = 1'b0;
        idle(4);

        // Thread 0 after reset: qtd 1, ign 0, four beats.
        cfg_qtd(3'd0, 64'd1);
        for (int i = 0; i < 4; i++) begin
            beat(3'd0, 32'(i + 1), (i == 0) || !QTD);
            check("t0_qtd1_done", 64'(done[0]), 64'd1);
        end
        idle(6);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/cgra0_out_stream_writer.md
# cgra0_out_stream_writer

Output-side stream writer for the CGRA: the transmitting end of the per-thread ignore/quantity stream protocol whose receiving end is the input PE's FIFO reader. It takes result beats tagged with a thread index from the PE array, discards each thread's first N beats, forwards at most Q beats per thread into the accelerator output FIFO through a 2-entry skid buffer, and flags per-thread completion. Limits are loaded through the same conf-reader strobes (thread_id, ignore_we, qtd low/high) as the input side.

## Interface
- NUM_THREADS, 7, hardware threads (thread index width 3)
- DATA_WIDTH, 32, data beat width
- IGNORE_WIDTH, 16, ignore limit/counter width
- QTD_WIDTH, 64, quantity limit/counter width (loaded as two 32-bit halves)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; low freezes all state except config writes
- in_valid  in  1  result beat present
- in_thread  in  3  thread index of beat
- in_data  in  DATA_WIDTH  beat payload
- cfg_thread_id  in  3  thread targeted by config strobes
- cfg_ignore_we  in  1  load ignore limit
- cfg_ignore  in  IGNORE_WIDTH  ignore limit value
- cfg_qtd_we_low / cfg_qtd_we_high  in  1 each  load low/high quantity half
- cfg_qtd_low / cfg_qtd_high  in  32 each  quantity halves
- fifo_full  in  1  output FIFO cannot accept
- fifo_we  out  1  registered FIFO write strobe
- fifo_data  out  DATA_WIDTH  registered FIFO write data
- stall  out  1  skid buffer full; array must not present beats
- overflow  out  1  sticky: beat lost to full buffer
- done  out  NUM_THREADS  per-thread quantity reached

## Operation
- Beat counted when en & in_valid & in_thread < NUM_THREADS; in_thread ≥ 7 is dropped uncounted.
- Per thread: ign_cnt < ign_lim → beat discarded, ign_cnt++ (saturates at ign_lim). Else if qtd_cnt ≠ qtd_lim → beat pushed, qtd_cnt++ (64-bit, no wrap past limit). Else dropped.
- done[t] = (ign_cnt==ign_lim) & (qtd_cnt==qtd_lim); qtd_lim=0 → done after ignore phase, no writes.
- Config: cfg_ignore_we loads ign_lim[cfg_thread_id], clears its ign_cnt; cfg_qtd_we_low/high loads that half, clears qtd_cnt. Config writes ignore en.
- Config write and beat on same thread same cycle: config wins; beat dropped and not counted. Different threads: both proceed.
- Skid buffer: 2-entry FIFO, count 0..2. stall = (count==2), combinational from registered count.
- Push when count==2 and no pop same cycle: beat lost, overflow set (cleared only by reset); counters still advance.
- Simultaneous push and pop at count==2: legal, count stays 2.
- Pop when en & ~fifo_full & count>0: fifo_we<=1, fifo_data<=head; otherwise fifo_we<=0, fifo_data holds.
- Beats of one thread leave in arrival order; interleaving across threads preserved.

## Timing
- Reset (rst=0, async): fifo_we=0, fifo_data=0, stall=0, overflow=0, count=0, all counters and limits 0, so done=all-ones.
- Latency: beat presented in cycle k with empty buffer and fifo_full=0 in k+1 → fifo_we high in cycle k+2.
- fifo_we is a one-cycle pulse per beat; back-to-back beats give continuous fifo_we.
- fifo_full sampled in the pop-decision cycle; FIFO must absorb a write issued the cycle before full rose (one-entry slack).
- Counter and done updates visible the cycle after the counted beat/config write.
- en low: no push, no pop, fifo_we=0 next cycle, stall held.

## Configuration
- CGRA_OUT_QTD_EN defined: quantity registers, 64-bit counters and quantity gating as above.
- Undefined: no quantity logic; every post-ignore beat pushed; cfg_qtd_* ignored; done[t] = (ign_cnt==ign_lim).

## Test plan
- Reset then thread 0 ign=2, qtd=3; five beats 0xA..0xE thread 0 → fifo_data 0xC,0xD,0xE, done[0]=1 after 5th beat; sixth beat produces no fifo_we.
- Single beat 0x55 thread 3, limits 0/5 → fifo_we high exactly cycle k+2, fifo_data=0x55, done[3]=0.
- fifo_full held high, three beats of thread 1 → stall after 2nd, 3rd lost, overflow=1; release full → exactly two writes in order.
- Beat on thread 2 with cfg_ignore_we to thread 2 same cycle (ign=1) → beat not counted; next beat discarded, following beat written.
- in_thread=7 beats and en=0 beats → no fifo_we, counters unchanged; rst pulse mid-burst clears buffer, fifo_we=0, done=all-ones.
- CGRA_OUT_QTD_EN undefined, qtd=1 loaded, ign=0, four beats → four writes, done[0]=1 throughout.
